// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause-22 MDIO responder (PHY side) with oversampled MDC/MDIO
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd4,
    parameter int         PREAMBLE_MIN = 32,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mdc_pin,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        reg_wr_strobe,
    input  logic [15:0] reg_rd_data,
    output logic        busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_DATA  = 3'd6;
    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
    logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
    logic        mdc_prev_q, mdc_prev_d;
    logic [2:0]  state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  addr_sh_q, addr_sh_d;
    logic [15:0] data_sh_q, data_sh_d;
    logic        is_read_q, is_read_d;
    logic        foreign_q, foreign_d;
    logic        rd_latch_q, rd_latch_d;
    logic        ta_drive_q, ta_drive_d;
    logic        oe_q, oe_d;
    logic        out_q, out_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;

    logic mdc_s, mdio_s, mdc_rise, mdc_fall;
    logic [4:0] addr_next;

    assign mdc_s     = mdc_sync_q[SYNC_STAGES-1];
    assign mdio_s    = mdio_sync_q[SYNC_STAGES-1];
    assign mdc_rise  = mdc_s & ~mdc_prev_q;
    assign mdc_fall  = ~mdc_s & mdc_prev_q;
    assign addr_next = {addr_sh_q[3:0], mdio_s};

    always_comb begin
        mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc_pin};
        mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_in};
        mdc_prev_d  = mdc_s;
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        cnt_d       = cnt_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        is_read_d   = is_read_q;
        foreign_d   = foreign_q;
        rd_latch_d  = 1'b0;
        ta_drive_d  = ta_drive_q;
        oe_d        = oe_q;
        out_d       = out_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        strobe_d    = 1'b0;
        busy_d      = busy_q;

        // Read data is captured one clock after reg_addr settles so the bank can decode it.
        if (rd_latch_q) begin
            data_sh_d = reg_rd_data;
        end

        if (mdc_rise) begin
            case (state_q)
                S_IDLE: begin
                    if (mdio_s) begin
                        if (pre_cnt_q != 6'd63) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q >= PRE_MIN) begin
                        state_d   = S_START;
                        busy_d    = 1'b1;
                        pre_cnt_d = 6'd0;
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end
                S_START: begin
                    cnt_d = 5'd0;
                    if (mdio_s) begin
                        state_d = S_OP;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                S_OP: begin
                    addr_sh_d = addr_next;
                    if (cnt_q == 5'd0) begin
                        cnt_d = 5'd1;
                    end else begin
                        cnt_d = 5'd0;
                        if (addr_sh_q[0] != mdio_s) begin
                            state_d   = S_PHYAD;
                            is_read_d = addr_sh_q[0];
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_PHYAD: begin
                    addr_sh_d = addr_next;
                    cnt_d     = cnt_q + 5'd1;
                    if (cnt_q == 5'd4) begin
                        foreign_d = (addr_next != PHY_ADDR);
                        state_d   = S_REGAD;
                        cnt_d     = 5'd0;
                    end
                end
                S_REGAD: begin
                    addr_sh_d = addr_next;
                    cnt_d     = cnt_q + 5'd1;
                    if (cnt_q == 5'd4) begin
                        if (!foreign_q) begin
                            reg_addr_d = addr_next;
                            rd_latch_d = is_read_q;
                        end
                        state_d = S_TA;
                        cnt_d   = 5'd0;
                    end
                end
                S_TA: begin
                    if (cnt_q == 5'd0) begin
                        cnt_d      = 5'd1;
                        ta_drive_d = is_read_q & ~foreign_q;
                    end else begin
                        cnt_d   = 5'd0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_q + 5'd1;
                    if (!is_read_q) begin
                        data_sh_d = {data_sh_q[14:0], mdio_s};
                        if (cnt_q == 5'd15) begin
                            if (!foreign_q) begin
                                wr_data_d = {data_sh_q[14:0], mdio_s};
                                strobe_d  = 1'b1;
                            end
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            cnt_d   = 5'd0;
                        end
                    end else if (foreign_q && cnt_q == 5'd15) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = 5'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end else if (mdc_fall) begin
            if (ta_drive_q) begin
                ta_drive_d = 1'b0;
                oe_d       = 1'b1;
                out_d      = 1'b0;
            end else if (state_q == S_DATA && is_read_q && !foreign_q) begin
                // cnt_q counts data rises; once all 16 have been sampled the pad is released.
                if (cnt_q == 5'd16) begin
                    oe_d    = 1'b0;
                    out_d   = 1'b1;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 5'd0;
                end else begin
                    out_d     = data_sh_q[15];
                    data_sh_d = {data_sh_q[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '1;
            mdc_prev_q  <= 1'b0;
            state_q     <= S_IDLE;
            pre_cnt_q   <= 6'd0;
            cnt_q       <= 5'd0;
            addr_sh_q   <= 5'd0;
            data_sh_q   <= 16'd0;
            is_read_q   <= 1'b0;
            foreign_q   <= 1'b0;
            rd_latch_q  <= 1'b0;
            ta_drive_q  <= 1'b0;
            oe_q        <= 1'b0;
            out_q       <= 1'b1;
            reg_addr_q  <= 5'd0;
            wr_data_q   <= 16'd0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            mdc_prev_q  <= mdc_prev_d;
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            cnt_q       <= cnt_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            is_read_q   <= is_read_d;
            foreign_q   <= foreign_d;
            rd_latch_q  <= rd_latch_d;
            ta_drive_q  <= ta_drive_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
        end
    end

    assign mdio_oe       = oe_q;
    assign mdio_out      = out_q;
    assign reg_addr      = reg_addr_q;
    assign reg_wr_data   = wr_data_q;
    assign reg_wr_strobe = strobe_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - Directed bench for mdio_responder acting as the station master
module tb_mdio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mdc_pin = 1'b0;
    logic        mdio_drv = 1'b1;
    logic        mdio_bus;
    logic        mdio_out;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_strobe;
    logic [15:0] reg_rd_data = 16'h0000;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int half = 2;
    int strobe_cnt = 0;
    int strobe_run = 0;
    int strobe_max = 0;
    int oe_cnt = 0;

    assign mdio_bus = mdio_oe ? mdio_out : mdio_drv;

    mdio_responder #(.PHY_ADDR(5'd4), .PREAMBLE_MIN(32), .SYNC_STAGES(2)) dut (
        .clock(clock),
        .reset(reset),
        .mdc_pin(mdc_pin),
        .mdio_in(mdio_bus),
        .mdio_out(mdio_out),
        .mdio_oe(mdio_oe),
        .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_wr_strobe(reg_wr_strobe),
        .reg_rd_data(reg_rd_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reg_wr_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_run = strobe_run + 1;
            if (strobe_run > strobe_max) strobe_max = strobe_run;
        end else begin
            strobe_run = 0;
        end
        if (mdio_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic mdc_bit(input logic b, output logic s);
        mdio_drv = b;
        wait_clks(half);
        mdc_pin = 1'b1;
        wait_clks(half);
        s = mdio_bus;
        mdc_pin = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        logic s;
        for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], s);
    endtask

    task automatic send_ones(input int n);
        logic s;
        for (int i = 0; i < n; i++) mdc_bit(1'b1, s);
    endtask

    task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] ra,
                               input logic [15:0] data);
        send_ones(pre);
        send_bits({46'd0, 4'b0101, phy, ra, 2'b10, data}, 32);
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] ra,
                              output logic [1:0] ta, output logic [15:0] d);
        logic s;
        send_ones(32);
        send_bits({50'd0, 4'b0110, phy, ra}, 14);
        mdc_bit(1'b1, s);
        mdc_bit(1'b1, s);
        ta = {mdio_oe, s};
        for (int i = 15; i >= 0; i--) begin
            mdc_bit(1'b1, s);
            d[i] = s;
        end
    endtask

    initial begin
        logic [1:0]  ta;
        logic [15:0] d;
        int s0, o0;
        logic        s;

        wait_clks(3);
        chk("rst_oe", 32'(mdio_oe), 32'd0);
        chk("rst_out", 32'(mdio_out), 32'd1);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdata", 32'(reg_wr_data), 32'd0);
        chk("rst_strobe", 32'(reg_wr_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_clks(2);

        // Basic write
        s0 = strobe_cnt; o0 = oe_cnt;
        write_frame(32, 5'd4, 5'd3, 16'hA55A);
        send_ones(2);
        chk("wr_strobes", 32'(strobe_cnt - s0), 32'd1);
        chk("wr_addr", 32'(reg_addr), 32'd3);
        chk("wr_data", 32'(reg_wr_data), 32'hA55A);
        chk("wr_no_oe", 32'(oe_cnt - o0), 32'd0);
        chk("wr_busy_end", 32'(busy), 32'd0);

        // Basic read
        reg_rd_data = 16'h1234;
        read_frame(5'd4, 5'd2, ta, d);
        chk("rd_ta", 32'(ta), 32'd2);
        chk("rd_data", 32'(d), 32'h1234);
        chk("rd_addr", 32'(reg_addr), 32'd2);
        send_ones(2);
        chk("rd_oe_release", 32'(mdio_oe), 32'd0);
        chk("rd_out_release", 32'(mdio_out), 32'd1);
        chk("rd_busy_end", 32'(busy), 32'd0);

        // Foreign PHY address, then an immediate own write
        s0 = strobe_cnt; o0 = oe_cnt;
        write_frame(32, 5'd7, 5'd9, 16'hDEAD);
        chk("foreign_strobe", 32'(strobe_cnt - s0), 32'd0);
        chk("foreign_oe", 32'(oe_cnt - o0), 32'd0);
        chk("foreign_addr", 32'(reg_addr), 32'd2);
        write_frame(32, 5'd4, 5'd17, 16'h5AA5);
        send_ones(2);
        chk("after_foreign_strobe", 32'(strobe_cnt - s0), 32'd1);
        chk("after_foreign_data", 32'(reg_wr_data), 32'h5AA5);
        chk("after_foreign_addr", 32'(reg_addr), 32'd17);

        // Foreign read must never drive
        o0 = oe_cnt;
        reg_rd_data = 16'hFFFF;
        read_frame(5'd5, 5'd1, ta, d);
        send_ones(2);
        chk("foreign_rd_oe", 32'(oe_cnt - o0), 32'd0);
        chk("foreign_rd_busy", 32'(busy), 32'd0);

        // Short preamble
        s0 = strobe_cnt;
        write_frame(20, 5'd4, 5'd3, 16'h1111);
        send_ones(2);
        chk("short_pre_strobe", 32'(strobe_cnt - s0), 32'd0);
        chk("short_pre_busy", 32'(busy), 32'd0);

        // Invalid opcode 11
        send_ones(32);
        send_bits(64'b01, 2);
        wait_clks(8);
        chk("badop_busy_start", 32'(busy), 32'd1);
        send_bits(64'b11, 2);
        wait_clks(8);
        chk("badop_busy_drop", 32'(busy), 32'd0);
        send_bits({54'd0, 5'd4, 5'd3}, 10);
        send_bits({46'd0, 2'b10, 16'h2222}, 18);
        send_ones(2);
        chk("badop_strobe", 32'(strobe_cnt - s0), 32'd0);

        // Reset in the middle of a read, during data bit 7
        reg_rd_data = 16'h0F0F;
        send_ones(32);
        send_bits({50'd0, 4'b0110, 5'd4, 5'd6}, 14);
        send_ones(2 + 8);
        chk("midrd_oe_before", 32'(mdio_oe), 32'd1);
        chk("midrd_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrd_oe_async", 32'(mdio_oe), 32'd0);
        chk("midrd_busy_async", 32'(busy), 32'd0);
        chk("midrd_out_async", 32'(mdio_out), 32'd1);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        reg_rd_data = 16'hC3A5;
        read_frame(5'd4, 5'd6, ta, d);
        chk("postrst_ta", 32'(ta), 32'd2);
        chk("postrst_data", 32'(d), 32'hC3A5);
        send_ones(2);

        // Back-to-back read then write at several MDC ratios
        for (int k = 0; k < 3; k++) begin
            half = (k == 0) ? 2 : (k == 1) ? 5 : 32;
            reg_rd_data = (k == 0) ? 16'hBEEF : (k == 1) ? 16'h8001 : 16'h7E7E;
            s0 = strobe_cnt;
            read_frame(5'd4, 5'd10, ta, d);
            mdc_bit(1'b1, s);
            chk("b2b_rd_ta", 32'(ta), 32'd2);
            chk("b2b_rd_data", 32'(d), (k == 0) ? 32'hBEEF : (k == 1) ? 32'h8001 : 32'h7E7E);
            write_frame(32, 5'd4, 5'd31, (k == 0) ? 16'h0F0F : (k == 1) ? 16'hFFFF : 16'h0001);
            send_ones(2);
            chk("b2b_wr_strobe", 32'(strobe_cnt - s0), 32'd1);
            chk("b2b_wr_data", 32'(reg_wr_data), (k == 0) ? 32'h0F0F : (k == 1) ? 32'hFFFF : 32'h0001);
            chk("b2b_wr_addr", 32'(reg_addr), 32'd31);
        end
        chk("strobe_width", 32'(strobe_max), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side (responder) end of the IEEE 802.3 clause-22 MDIO management interface.
- Oversamples an externally driven MDC/MDIO pair in the system clock domain and decodes preamble, start, opcode, PHY address and register address.
- Writes: delivers a one-clock register write strobe.
- Reads: fetches a word from an external register bank and drives it back on MDIO.
- Used as an emulated PHY management port and as the bench responder for the station-management master.

Parameters:
- PHY_ADDR, 5'd4: PHY address this responder answers to.
- PREAMBLE_MIN, 32: consecutive 1 bits required before a start-of-frame is accepted (1..63).
- SYNC_STAGES, 2: synchronizer depth on mdc_pin and mdio_in (>=2).

Ports:
- clock  input  1  system clock; all logic on posedge; frequency >= 4x MDC.
- reset  input  1  asynchronous, active-high reset.
- mdc_pin  input  1  management clock from the station master.
- mdio_in  input  1  MDIO pad input.
- mdio_out  output  1  MDIO pad output value.
- mdio_oe  output  1  MDIO pad output enable; 1 = drive mdio_out.
- reg_addr  output  5  register address of the current or last frame.
- reg_wr_data  output  16  write data; valid while reg_wr_strobe = 1.
- reg_wr_strobe  output  1  one-clock pulse per accepted write frame.
- reg_rd_data  input  16  read data from the bank for reg_addr; sampled once per read frame.
- busy  output  1  1 from accepted start bit until the frame ends.

Behaviour:
- Synchronization: mdc_pin and mdio_in each pass through SYNC_STAGES flops.
  - MDC rise = synced 0->1; MDC fall = synced 1->0.
  - MDIO is sampled only on MDC rise events; outputs change only on MDC fall events, or on reset.
- Reset values: mdio_oe=0, mdio_out=1, reg_addr=0, reg_wr_data=0, reg_wr_strobe=0, busy=0, state=IDLE, preamble count=0.
- Reset asserted mid-frame aborts immediately (oe drops asynchronously); a full new preamble is then required.
- States (transitions on MDC rise unless stated):
  - IDLE: each sampled 1 increments the preamble count (saturating at 63); a sampled 0 with count < PREAMBLE_MIN clears it. A sampled 0 with count >= PREAMBLE_MIN -> START and sets busy.
  - START: sampled 1 -> OP. Sampled 0 -> IDLE with count=0.
  - OP: collect 2 bits. 10 = read, 01 = write -> PHYAD. 00 or 11 -> IDLE with count=0.
  - PHYAD: collect 5 bits MSB first. A mismatch with PHY_ADDR still proceeds, but the frame is flagged foreign.
  - REGAD: collect 5 bits MSB first. Own frame: reg_addr updates on the 5th bit. Own read: reg_rd_data is latched into the shift register 1 clock after that update. -> TA.
  - TA: first rise -> (own read) on the next MDC fall set mdio_oe=1, mdio_out=0. Write TA bit values are ignored. -> DATA after the second rise.
  - DATA: 16 bits. Write: shift in MSB first; on the 16th rise, own frame -> reg_wr_data loaded and reg_wr_strobe=1 for exactly one clock. Read: on each MDC fall drive the next bit, bit 15 first. The fall after bit 0 is driven sets mdio_oe=0, mdio_out=1. -> IDLE with count=0, busy=0 at frame end.
- Foreign frame: all bits are tracked, but mdio_oe never asserts and no strobe fires.
- reg_wr_strobe latency: 1 clock after the synchronized 16th data rise is detected.
- MDC stopped mid-frame: state holds indefinitely with no timeout; the frame resumes when MDC resumes.
- mdio_in is ignored for decoding while mdio_oe=1.

Test Plan:
- Write frame: 32 ones, 01, 01, 00100, 00011, 10, data 16'hA55A. -> exactly one reg_wr_strobe, reg_addr=3, reg_wr_data=16'hA55A; mdio_oe stays 0 throughout.
- Read frame: reg_rd_data=16'h1234, 32 ones, 01, 10, 00100, 00010. -> mdio_oe rises on the fall after TA bit 1, drives 0 then 0001_0010_0011_0100 MSB first, drops after bit 0; master captures 16'h1234.
- Address mismatch: write frame to PHYAD 00111. -> no strobe, no drive. An immediate following write to PHYAD 4 with a full preamble -> strobe with correct data.
- Short preamble: 20 ones then a valid write frame. -> no strobe. Invalid opcode 11 after a full preamble -> returns to IDLE, no strobe, busy drops.
- Reset mid-read during data bit 7. -> mdio_oe=0 and busy=0 immediately. The next full read frame returns reg_rd_data correctly.
- Back-to-back read then write at MDC = clock/4, clock/10 and clock/64. -> correct data each time; strobe width exactly 1 clock.
